// File: rtl/fpadd_param.sv
// Multi-cycle parametrised floating-point adder/subtractor with a start/done handshake.
// Optional feature macro: FPADD_RNE_EN selects round-to-nearest-even; when undefined, ROUND truncates.
module fpadd_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 op_sub,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic [EXP_W+MAN_W:0] result,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf,
    output logic                 inv
);
    localparam int W  = EXP_W + MAN_W + 1;
    localparam int SW = MAN_W + 4;   // {hidden, frac, G, R, S}
    localparam logic [EXP_W-1:0] EMAX   = '1;
    localparam logic [EXP_W-1:0] SH_MAX = EXP_W'(MAN_W + 3);
    localparam logic [EXP_W:0]   E_ONE  = (EXP_W+1)'(1);
    localparam logic [W-1:0]     QNAN   = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, SPECIAL, ALIGN, ADD, NORM, ROUND, PACK, DONE} state_t;
    state_t state;

    logic [W-1:0]   opa, opb;   // opb already carries the effective sign
    logic           sign_r, eff_sub;
    logic [EXP_W:0] exp_r;      // one spare bit so a rounding carry past all-ones cannot wrap
    logic [SW-1:0]  big_m, sml_m;
    logic [SW:0]    mant;

    logic               sa, sb;
    logic [EXP_W-1:0]   ea, eb;
    logic [MAN_W-1:0]   fa, fb;
    assign {sa, ea, fa} = opa;
    assign {sb, eb, fb} = opb;

    logic nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    assign nan_a  = (ea == EMAX) && (fa != '0);
    assign nan_b  = (eb == EMAX) && (fb != '0);
    assign inf_a  = (ea == EMAX) && (fa == '0);
    assign inf_b  = (eb == EMAX) && (fb == '0);
    assign zero_a = (ea == '0);
    assign zero_b = (eb == '0);

    // Alignment: larger magnitude is the big operand; shifted-out bits collapse into S.
    logic             a_big, lost;
    logic [EXP_W-1:0] ebig, diff, shamt;
    logic [SW-1:0]    mbig_ext, msml_ext, msml_sh;
    assign a_big    = {ea, fa} >= {eb, fb};
    assign ebig     = a_big ? ea : eb;
    assign diff     = a_big ? ea - eb : eb - ea;
    assign shamt    = (diff > SH_MAX) ? SH_MAX : diff;
    assign mbig_ext = {1'b1, a_big ? fa : fb, 3'b000};
    assign msml_ext = {1'b1, a_big ? fb : fa, 3'b000};
    assign msml_sh  = msml_ext >> shamt;
    assign lost     = |(msml_ext & ~({SW{1'b1}} << shamt));

    logic [SW:0] sum;
    assign sum = eff_sub ? ({1'b0, big_m} - {1'b0, sml_m}) : ({1'b0, big_m} + {1'b0, sml_m});

    logic             inc;
    logic [MAN_W+1:0] rounded;
`ifdef FPADD_RNE_EN
    assign inc = mant[2] & (mant[1] | mant[0] | mant[3]);
`else
    assign inc = 1'b0;
`endif
    assign rounded = {1'b0, mant[SW-1:3]} + (MAN_W+2)'(inc);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            result  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
            inv     <= 1'b0;
            opa     <= '0;
            opb     <= '0;
            sign_r  <= 1'b0;
            eff_sub <= 1'b0;
            exp_r   <= '0;
            big_m   <= '0;
            sml_m   <= '0;
            mant    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    opa   <= a;
                    opb   <= {b[W-1] ^ op_sub, b[W-2:0]};
                    ovf   <= 1'b0;
                    inv   <= 1'b0;
                    busy  <= 1'b1;
                    state <= SPECIAL;
                end
                SPECIAL: begin
                    state <= DONE;
                    if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) begin
                        result <= QNAN;
                        inv    <= 1'b1;
                    end else if (inf_a)             result <= opa;
                    else if (inf_b)                 result <= opb;
                    else if (zero_a && zero_b)      result <= {sa & sb, {(W-1){1'b0}}};
                    else if (zero_a)                result <= opb;
                    else if (zero_b)                result <= opa;
                    else begin
                        eff_sub <= sa ^ sb;
                        state   <= ALIGN;
                    end
                end
                ALIGN: begin
                    sign_r <= a_big ? sa : sb;
                    exp_r  <= {1'b0, ebig};
                    big_m  <= mbig_ext;
                    sml_m  <= {msml_sh[SW-1:1], msml_sh[0] | lost};
                    state  <= ADD;
                end
                ADD: begin
                    if (sum == '0) begin
                        result <= '0;
                        state  <= DONE;
                    end else begin
                        mant  <= sum;
                        state <= NORM;
                    end
                end
                NORM: begin
                    if (mant[SW]) begin
                        mant  <= {1'b0, mant[SW:2], mant[1] | mant[0]};
                        exp_r <= exp_r + E_ONE;
                        state <= ROUND;
                    end else if (mant[SW-1]) begin
                        state <= ROUND;
                    end else if (exp_r == E_ONE) begin
                        result <= {sign_r, {(W-1){1'b0}}};
                        state  <= DONE;
                    end else begin
                        // Leave as soon as the shifted value is normalised to save a cycle.
                        mant  <= {mant[SW-1:0], 1'b0};
                        exp_r <= exp_r - E_ONE;
                        if (mant[SW-2]) state <= ROUND;
                    end
                end
                ROUND: begin
                    if (rounded[MAN_W+1]) begin
                        mant  <= {1'b0, rounded[MAN_W+1:1], 3'b000};
                        exp_r <= exp_r + E_ONE;
                    end else begin
                        mant  <= {1'b0, rounded[MAN_W:0], 3'b000};
                    end
                    state <= PACK;
                end
                PACK: begin
                    if (exp_r >= {1'b0, EMAX}) begin
                        result <= {sign_r, EMAX, {MAN_W{1'b0}}};
                        ovf    <= 1'b1;
                    end else begin
                        result <= {sign_r, exp_r[EXP_W-1:0], mant[SW-2:3]};
                    end
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpadd_param.sv
// Scoreboard bench for fpadd_param: single precision plus a half-precision instance.
module tb_fpadd_param;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        start, op_sub, busy, done, ovf, inv;
    logic [31:0] a, b, result;
    logic        h_start, h_op_sub, h_busy, h_done, h_ovf, h_inv;
    logic [15:0] h_a, h_b, h_result;

    fpadd_param #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .reset(reset), .start(start), .op_sub(op_sub), .a(a), .b(b),
        .result(result), .busy(busy), .done(done), .ovf(ovf), .inv(inv)
    );
    fpadd_param #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .reset(reset), .start(h_start), .op_sub(h_op_sub), .a(h_a), .b(h_b),
        .result(h_result), .busy(h_busy), .done(h_done), .ovf(h_ovf), .inv(h_inv)
    );

`ifdef FPADD_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        inv;
        int          id;
    } exp_t;

    exp_t q[$], qh[$];
    exp_t me, mh;
    int checks = 0, failures = 0, n_done = 0, opn = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_done++;
            chk("sb_pending", 64'(q.size() > 0), 1);
            if (q.size() > 0) begin
                me = q.pop_front();
                chk($sformatf("res%0d", me.id), 64'(result), 64'(me.res));
                chk($sformatf("ovf%0d", me.id), 64'(ovf), 64'(me.ovf));
                chk($sformatf("inv%0d", me.id), 64'(inv), 64'(me.inv));
            end
        end
    end

    always @(negedge clk) begin
        if (h_done === 1'b1) begin
            chk("h_sb_pending", 64'(qh.size() > 0), 1);
            if (qh.size() > 0) begin
                mh = qh.pop_front();
                chk($sformatf("h_res%0d", mh.id), 64'(h_result), 64'(mh.res));
                chk($sformatf("h_ovf%0d", mh.id), 64'(h_ovf), 64'(mh.ovf));
                chk($sformatf("h_inv%0d", mh.id), 64'(h_inv), 64'(mh.inv));
            end
        end
    end

    // Called at a falling edge; returns one falling edge after start was sampled.
    task automatic issue(input bit h, input logic [31:0] ia, input logic [31:0] ib, input logic sub,
                         input logic [31:0] er, input logic eo, input logic ei);
        exp_t e;
        e.res = er; e.ovf = eo; e.inv = ei; e.id = opn;
        opn++;
        if (h) begin
            qh.push_back(e);
            h_a = ia[15:0]; h_b = ib[15:0]; h_op_sub = sub; h_start = 1'b1;
        end else begin
            q.push_back(e);
            a = ia; b = ib; op_sub = sub; start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        h_start = 1'b0;
    endtask

    task automatic wait_done(input bit h, output int lat);
        lat = 1;
        while (!(h ? h_done : done) && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk(h ? "h_done_seen" : "done_seen", 64'(h ? h_done : done), 1);
        chk(h ? "h_busy_at_done" : "busy_at_done", 64'(h ? h_busy : busy), 0);
    endtask

    task automatic run(input bit h, input logic [31:0] ia, input logic [31:0] ib, input logic sub,
                       input logic [31:0] er, input logic eo, input logic ei, output int lat);
        issue(h, ia, ib, sub, er, eo, ei);
        chk(h ? "h_busy_after_start" : "busy_after_start", 64'(h ? h_busy : busy), 1);
        wait_done(h, lat);
        @(negedge clk);
        chk(h ? "h_done_one_cycle" : "done_one_cycle", 64'(h ? h_done : done), 0);
    endtask

    initial begin
        int lat, d0;
        reset = 1'b1;
        start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
        h_start = 1'b0; h_op_sub = 1'b0; h_a = '0; h_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_result", 64'(result), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_flags", 64'({ovf, inv}), 0);
        chk("rst_h_result", 64'(h_result), 0);
        reset = 1'b0;
        @(negedge clk);

        run(0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0, lat);
        chk("lat_normal_max", 64'(lat <= 32), 1);
        run(0, 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0, lat);
        run(0, 32'h40400000, 32'hBF800000, 1'b0, 32'h40000000, 1'b0, 1'b0, lat);
        run(0, 32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 1'b0, 1'b0, lat);
        chk("lat_long_norm", 64'(lat <= 32), 1);
        run(0, 32'h3F800000, 32'hBF800000, 1'b1, 32'h40000000, 1'b0, 1'b0, lat);
        run(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0, lat);
        run(0, 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1'b0, 1'b1, lat);
        chk("lat_special", 64'(lat), 3);
        run(0, 32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b1, lat);
        run(0, 32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 1'b0, 1'b0, lat);
        chk("lat_zero_pass", 64'(lat), 3);
        run(0, 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b0, lat);
        run(0, 32'h80000000, 32'h80000000, 1'b1, 32'h00000000, 1'b0, 1'b0, lat);
        run(0, 32'h3F800000, 32'h33C00000, 1'b0, RNE ? 32'h3F800001 : 32'h3F800000, 1'b0, 1'b0, lat);
        run(0, 32'h3F800001, 32'h33800000, 1'b0, RNE ? 32'h3F800002 : 32'h3F800001, 1'b0, 1'b0, lat);

        // Start in the same cycle as done is accepted.
        issue(0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0);
        wait_done(0, lat);
        issue(0, 32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1'b0, 1'b0);
        chk("b2b_busy", 64'(busy), 1);
        wait_done(0, lat);
        chk("b2b_lat", 64'(lat), 3);
        @(negedge clk);

        // A start while busy is ignored.
        d0 = n_done;
        issue(0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0);
        a = 32'h7F800000; b = 32'hFF800000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(0, lat);
        repeat (10) @(negedge clk);
        chk("busy_start_ignored", 64'(n_done), 64'(d0 + 1));

        // Reset while in the normalisation loop aborts without a done.
        a = 32'h3F800001; b = 32'h3F800000; op_sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_abort_busy", 64'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 64'(busy), 0);
        chk("abort_result", 64'(result), 0);
        d0 = n_done;
        repeat (40) @(negedge clk);
        chk("abort_no_done", 64'(n_done), 64'(d0));
        run(0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0, lat);

        run(1, 32'h3C00, 32'h3C00, 1'b0, 32'h4000, 1'b0, 1'b0, lat);
        run(1, 32'h7BFF, 32'h7BFF, 1'b0, 32'h7C00, 1'b1, 1'b0, lat);

        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(q.size() + qh.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
